// File: rtl/uart_rx_deserializer.sv
// Oversampling UART receiver: majority-voted bit sampling, optional parity, registered pulses.
// Parity support is compiled in only when UART_RX_PARITY_EN is defined.
module uart_rx_deserializer #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PRESCALE_W = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx_in,
  input  logic [PRESCALE_W-1:0] prescale_in,
  input  logic                  par_en_in,
  input  logic                  par_type_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid_out,
  output logic                  par_err_out,
  output logic                  stop_err_out,
  output logic                  busy_out
);

  localparam int unsigned BitW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [PRESCALE_W-1:0] CntOne = PRESCALE_W'(1);
  localparam logic [BitW-1:0] BitOne = BitW'(1);
  localparam logic [BitW-1:0] BitLast = BitW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StStart  = 3'd1,
    StData   = 3'd2,
`ifdef UART_RX_PARITY_EN
    StParity = 3'd3,
`endif
    StStop   = 3'd4
  } state_e;

  state_e state_q, state_d;

  logic [PRESCALE_W-1:0] cnt_q, cnt_d;
  logic [BitW-1:0]       bit_q, bit_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  s0_q, s0_d;
  logic                  s1_q, s1_d;
  logic                  frame_bad_q, frame_bad_d;
  logic                  load_q, load_d;
  logic                  valid_q;
  logic                  stop_err_q, stop_err_d;

  logic [PRESCALE_W-1:0] half;
  logic [PRESCALE_W-1:0] samp_a;
  logic [PRESCALE_W-1:0] samp_c;
  logic                  wrap;
  logic                  resolve;
  logic                  maj;

  // Sample points straddle the nominal bit centre; the third vote is the live input.
  assign half    = prescale_in >> 1;
  assign samp_a  = half - CntOne;
  assign samp_c  = half + CntOne;
  assign wrap    = (cnt_q == (prescale_in - CntOne));
  assign resolve = (cnt_q == samp_c);
  assign maj     = (s0_q & s1_q) | (s0_q & rx_in) | (s1_q & rx_in);

`ifdef UART_RX_PARITY_EN
  logic par_err_q, par_err_d;
  logic par_exp;

  assign par_exp = (^shift_q) ^ par_type_in;
`else
  logic unused_par_cfg;

  assign unused_par_cfg = par_en_in ^ par_type_in;
`endif

  always_comb begin
    s0_d = s0_q;
    s1_d = s1_q;
    if (state_q != StIdle) begin
      if (cnt_q == samp_a) s0_d = rx_in;
      if (cnt_q == half)   s1_d = rx_in;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    frame_bad_d = frame_bad_q;
    load_d      = 1'b0;
    stop_err_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_err_d   = 1'b0;
`endif

    if (state_q != StIdle) begin
      cnt_d = wrap ? '0 : (cnt_q + CntOne);
    end

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        bit_d = '0;
        if (!rx_in) begin
          state_d     = StStart;
          frame_bad_d = 1'b0;
        end
      end

      StStart: begin
        // A start bit that votes high was noise; abandon without any pulse.
        if (resolve && maj) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (wrap) begin
          state_d = StData;
        end
      end

      StData: begin
        if (resolve) begin
          shift_d = DATA_WIDTH'({maj, shift_q} >> 1);
        end
        if (wrap) begin
          if (bit_q == BitLast) begin
            bit_d = '0;
`ifdef UART_RX_PARITY_EN
            state_d = par_en_in ? StParity : StStop;
`else
            state_d = StStop;
`endif
          end else begin
            bit_d = bit_q + BitOne;
          end
        end
      end

`ifdef UART_RX_PARITY_EN
      StParity: begin
        if (resolve && (maj != par_exp)) begin
          par_err_d   = 1'b1;
          frame_bad_d = 1'b1;
        end
        if (wrap) begin
          state_d = StStop;
        end
      end
`endif

      StStop: begin
        // Leave half a bit early so a back-to-back start edge is not missed.
        if (resolve) begin
          if (!maj) begin
            stop_err_d = 1'b1;
          end else if (!frame_bad_q) begin
            load_d = 1'b1;
          end
          state_d = StIdle;
          cnt_d   = '0;
        end
      end

      default: begin
        state_d = StIdle;
        cnt_d   = '0;
        bit_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      s0_q        <= 1'b1;
      s1_q        <= 1'b1;
      frame_bad_q <= 1'b0;
      load_q      <= 1'b0;
      stop_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      s0_q        <= s0_d;
      s1_q        <= s1_d;
      frame_bad_q <= frame_bad_d;
      load_q      <= load_d;
      stop_err_q  <= stop_err_d;
    end
  end

  // The shift register is stable until the next DATA state, so the load can lag a cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= load_q;
      if (load_q) begin
        data_q <= shift_q;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      par_err_q <= 1'b0;
    end else begin
      par_err_q <= par_err_d;
    end
  end

  assign par_err_out = par_err_q;
`else
  assign par_err_out = 1'b0;
`endif

  assign data_out       = data_q;
  assign data_valid_out = valid_q;
  assign stop_err_out   = stop_err_q;
  assign busy_out       = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Scoreboarded bench for uart_rx_deserializer: stimulus pushes expected pulses, a monitor pops them.
module tb_uart_rx_deserializer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx_in = 1'b1;
  logic [5:0] prescale_in = 6'd16;
  logic       par_en_in = 1'b0;
  logic       par_type_in = 1'b0;
  logic [7:0] data_out;
  logic       data_valid_out;
  logic       par_err_out;
  logic       stop_err_out;
  logic       busy_out;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  logic [7:0] last_good = 8'h00;

  // kind: 0 = data_valid, 1 = par_err, 2 = stop_err
  typedef struct {
    int         kind;
    logic [7:0] data;
    int         at;
  } ev_t;

  ev_t exp_q[$];

  uart_rx_deserializer #(
    .DATA_WIDTH(8),
    .PRESCALE_W(6)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .rx_in         (rx_in),
    .prescale_in   (prescale_in),
    .par_en_in     (par_en_in),
    .par_type_in   (par_type_in),
    .data_out      (data_out),
    .data_valid_out(data_valid_out),
    .par_err_out   (par_err_out),
    .stop_err_out  (stop_err_out),
    .busy_out      (busy_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int actual, input int required);
    checks++;
    if (actual != required) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, required, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input int kind, input logic [7:0] data, input int at);
    ev_t e;
    e.kind = kind;
    e.data = data;
    e.at   = at;
    exp_q.push_back(e);
  endtask

  // Expected timing is counted from the first edge that sees the start bit low.
  task automatic send(input int ps, input logic [7:0] data, input logic pen, input logic ptype,
                      input logic pbit, input logic sbit);
    int t0;
    int p;
    logic par_on;
    logic par_bad;
    prescale_in = 6'(ps);
    par_en_in   = pen;
    par_type_in = ptype;
`ifdef UART_RX_PARITY_EN
    par_on = pen;
`else
    par_on = 1'b0;
`endif
    p       = par_on ? 1 : 0;
    par_bad = par_on && (pbit != ((^data) ^ ptype));
    t0      = cyc + 1;
    if (par_bad) push(1, 8'h00, t0 + 9 * ps + ps / 2 + 2);
    if (!sbit) push(2, 8'h00, t0 + (9 + p) * ps + ps / 2 + 2);
    if (!par_bad && sbit) begin
      push(0, data, t0 + (9 + p) * ps + ps / 2 + 3);
      last_good = data;
    end
    rx_in = 1'b0;
    tick(ps);
    for (int i = 0; i < 8; i++) begin
      rx_in = data[i];
      tick(ps);
    end
    if (par_on) begin
      rx_in = pbit;
      tick(ps);
    end
    rx_in = sbit;
    tick(ps);
    rx_in = 1'b1;
  endtask

  task automatic check_event(input int kind);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_pulse: kind %0d at cycle %0d, expected none", kind, cyc);
    end else begin
      e = exp_q.pop_front();
      check("pulse_kind", kind, e.kind);
      check("pulse_cycle", cyc, e.at);
      if (kind == 0) check("data_out", int'(data_out), int'(e.data));
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (data_valid_out) check_event(0);
      if (par_err_out)    check_event(1);
      if (stop_err_out)   check_event(2);
    end
  end

  initial begin
    tick(3);
    check("rst_data", int'(data_out), 0);
    check("rst_valid", int'(data_valid_out), 0);
    check("rst_par", int'(par_err_out), 0);
    check("rst_stop", int'(stop_err_out), 0);
    check("rst_busy", int'(busy_out), 0);
    reset = 1'b0;
    tick(4);
    check("post_rst_busy", int'(busy_out), 0);
    check("post_rst_data", int'(data_out), 0);

    // Good frame, then a stop-bit error that must leave data_out alone.
    send(16, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1);
    tick(10);
    send(16, 8'h81, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(10);
    check("hold_after_stop_err", int'(data_out), int'(last_good));

    // Short low glitch at prescale 32.
    prescale_in = 6'd32;
    tick(2);
    rx_in = 1'b0;
    tick(4);
    check("glitch_busy_hi", int'(busy_out), 1);
    rx_in = 1'b1;
    tick(30);
    check("glitch_busy_lo", int'(busy_out), 0);
    send(32, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b1);
    tick(5);

    // Back-to-back frames with no idle gap.
    send(16, 8'h55, 1'b0, 1'b0, 1'b0, 1'b1);
    send(16, 8'hAA, 1'b0, 1'b0, 1'b0, 1'b1);
    send(8, 8'hC3, 1'b0, 1'b0, 1'b0, 1'b1);
    tick(10);

`ifdef UART_RX_PARITY_EN
    send(8, 8'h3C, 1'b1, 1'b0, 1'b1, 1'b1);
    tick(10);
    check("hold_after_par_err", int'(data_out), int'(last_good));
    send(8, 8'h3C, 1'b1, 1'b1, 1'b1, 1'b1);
    tick(6);
    send(8, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(10);
    check("hold_after_both_err", int'(data_out), int'(last_good));
`else
    send(8, 8'h3C, 1'b1, 1'b0, 1'b1, 1'b1);
    tick(10);
`endif

    // Reset in the middle of data bit 4 of 0xFF.
    prescale_in = 6'd16;
    par_en_in   = 1'b0;
    rx_in       = 1'b0;
    tick(16);
    rx_in = 1'b1;
    tick(16 * 4 + 8);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_data", int'(data_out), 0);
    check("mid_rst_valid", int'(data_valid_out), 0);
    check("mid_rst_par", int'(par_err_out), 0);
    check("mid_rst_stop", int'(stop_err_out), 0);
    check("mid_rst_busy", int'(busy_out), 0);
    tick(3);
    reset     = 1'b0;
    last_good = 8'h00;
    tick(80);
    check("after_rst_busy", int'(busy_out), 0);
    check("after_rst_data", int'(data_out), 0);
    send(16, 8'h12, 1'b0, 1'b0, 1'b0, 1'b1);
    tick(40);

    check("pending_events", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_deserializer.md
UART_RX_DESERIALIZER -- requirements
Module: uart_rx_deserializer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, number of data bits per frame.
REQ-002 SHALL have parameter PRESCALE_W, default 6, width of prescale_in.
REQ-003 clk  input  1  sole clock; runs at prescale_in x baud rate.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 rx_in  input  1  serial line; idle high; already synchronized upstream.
REQ-006 prescale_in  input  PRESCALE_W  oversampling ratio; legal values 8, 16, 32; held stable while busy_out=1.
REQ-007 par_en_in  input  1  1 = frame carries a parity bit.
REQ-008 par_type_in  input  1  0 = even parity, 1 = odd parity.
REQ-009 data_out  output  DATA_WIDTH  last good received word, LSB received first.
REQ-010 data_valid_out  output  1  one-cycle pulse when data_out is updated.
REQ-011 par_err_out  output  1  one-cycle pulse on parity mismatch.
REQ-012 stop_err_out  output  1  one-cycle pulse on stop bit sampled low.
REQ-013 busy_out  output  1  high in every state except IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP.
- IDLE -> START when rx_in=0.
REQ-015 SHALL count clk edges per bit in an edge counter 0..prescale_in-1.
- Wraps to 0 at the bit boundary.
- Bit counter advances in DATA on each wrap.
REQ-016 SHALL sample each bit by 2-of-3 majority of rx_in at edge counts prescale_in/2-1, prescale_in/2 and prescale_in/2+1.
- Bit value resolved at count prescale_in/2+1.
REQ-017 START: resolved bit=1 (glitch) -> IDLE at that cycle; no output pulse.
- Resolved bit=0 -> DATA at next edge-counter wrap.
REQ-018 DATA: SHALL shift resolved bits into a DATA_WIDTH shift register LSB first.
- After bit DATA_WIDTH-1 completes -> PARITY if parity enabled (REQ-030), else STOP.
REQ-019 PARITY: SHALL compare resolved bit with XOR of data bits; for odd parity (par_type_in=1) the expected bit is inverted.
- Mismatch -> pulse par_err_out one cycle at resolve point and mark frame bad.
- Goes to STOP at wrap.
REQ-020 STOP: resolved bit=0 -> pulse stop_err_out one cycle.
- Resolved 1 and frame not bad -> load data_out and pulse data_valid_out one cycle later.
- Goes to IDLE immediately after the resolve point (half-bit early), so a back-to-back start bit is caught.
REQ-021 On a bad frame, data_out SHALL retain its previous value.
REQ-022 par_err_out and stop_err_out MAY pulse in the same frame, on different cycles; data_valid_out SHALL NOT pulse for that frame.
REQ-023 rx_in SHALL be ignored outside the sample windows.
- Exception: in IDLE, rx_in is monitored every cycle.
REQ-024 Frame latency: data_valid_out pulses (1 + DATA_WIDTH + P) x prescale_in + prescale_in/2 + 3 cycles after the first IDLE cycle with rx_in=0, where P = 1 if parity enabled, else 0.

Reset
REQ-025 reset SHALL asynchronously force state IDLE and clear the edge counter, bit counter and shift register.
REQ-026 During and after reset: data_out=0, data_valid_out=0, par_err_out=0, stop_err_out=0, busy_out=0.
REQ-027 Reset asserted mid-frame SHALL discard the partial frame with no pulse.
- After release, the FSM waits for the next falling rx_in in IDLE.

Configuration
REQ-028 Macro UART_RX_PARITY_EN SHALL select parity support.
REQ-029 Defined: PARITY state built; parity enabled when par_en_in=1.
REQ-030 Undefined: PARITY state and checker omitted; par_en_in and par_type_in ignored; par_err_out tied 0; frames never carry a parity bit.

Verification
REQ-031 Prescale 16, parity off, send 0xA5 with valid stop -> data_out=0xA5, single data_valid_out pulse at cycle 8 + 144 + 3 after start edge.
REQ-032 Prescale 8, UART_RX_PARITY_EN defined, par_en=1, even parity, send 0x3C with parity bit 1 -> par_err_out pulse, no data_valid_out, data_out unchanged.
REQ-033 Prescale 32, rx_in low for 4 cycles then high (glitch) -> FSM back to IDLE, busy_out low, no output pulses.
REQ-034 Prescale 16, send 0x81 with stop bit 0 -> stop_err_out pulse, no data_valid_out.
REQ-035 Two back-to-back frames 0x55, 0xAA with no idle gap -> two data_valid_out pulses, values in order.
REQ-036 Assert reset during DATA bit 4 of 0xFF -> all outputs 0 immediately; next frame 0x12 received correctly.
